// File: rtl/mempool_tcdm_req_tracker_pkg.sv
// Shared types for the TCDM request tracker: snitch-compatible request/response layout.
// Optional build macro MEMPOOL_TCDM_STATS_EN is consumed by the top.
package mempool_tcdm_req_tracker_pkg;

  localparam int unsigned MetaIdWidth = 4;

  typedef logic [MetaIdWidth-1:0] meta_id_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [3:0]  amo;
    logic [31:0] data;
    logic [3:0]  strb;
    meta_id_t    id;
  } dreq_t;

  typedef struct packed {
    logic [31:0] data;
    logic        error;
    meta_id_t    id;
  } dresp_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/mempool_tcdm_req_tracker_if.sv
// TCDM data-port bundle: request channel q, response channel p.
// master drives requests and accepts responses; slave is the opposite side.
interface mempool_tcdm_req_tracker_if;
  import mempool_tcdm_req_tracker_pkg::*;

  dreq_t  q;
  logic   q_valid;
  logic   q_ready;
  dresp_t p;
  logic   p_valid;
  logic   p_ready;

  modport master (output q, q_valid, p_ready, input q_ready, p, p_valid);
  modport slave  (input q, q_valid, p_ready, output q_ready, p, p_valid);
endinterface

// File: rtl/mempool_tcdm_req_tracker_spill.sv
// Two-entry spill register: full throughput, cuts both valid/data and ready paths.
module mempool_tcdm_req_tracker_spill #(
  parameter type T = logic
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic valid_i,
  output logic ready_o,
  input  T     data_i,
  output logic valid_o,
  input  logic ready_i,
  output T     data_o
);

  T     r_a_data, r_b_data;
  logic r_a_full, r_b_full;
  logic w_a_fill, w_a_drain, w_b_fill, w_b_drain;

  // Slot A takes new data; it spills into B only when the consumer stalls.
  assign w_a_fill  = valid_i & ready_o;
  assign w_a_drain = r_a_full & ~r_b_full;
  assign w_b_fill  = w_a_drain & ~ready_i;
  assign w_b_drain = r_b_full & ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_a_full <= 1'b0;
      r_b_full <= 1'b0;
      r_a_data <= '0;
      r_b_data <= '0;
    end else begin
      if (w_a_fill) r_a_data <= data_i;
      if (w_b_fill) r_b_data <= r_a_data;
      r_a_full <= w_a_fill | (r_a_full & ~w_a_drain);
      r_b_full <= w_b_fill | (r_b_full & ~w_b_drain);
    end
  end

  assign ready_o = ~r_a_full | ~r_b_full;
  assign valid_o = r_a_full | r_b_full;
  assign data_o  = r_b_full ? r_b_data : r_a_data;

endmodule

// File: rtl/mempool_tcdm_req_tracker.sv
// Tracks in-flight TCDM requests by id: blocks duplicate ids, caps outstanding count, honours fence.
// Define MEMPOOL_TCDM_STATS_EN to build the saturating stall-cycle counter.
module mempool_tcdm_req_tracker
  import mempool_tcdm_req_tracker_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 8,
  parameter bit          RegisterResp   = 1'b0
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  mempool_tcdm_req_tracker_if.slave         core,
  mempool_tcdm_req_tracker_if.master        tcdm,
  input  logic                              fence_i,
  output logic                              idle_o,
  output logic                              spurious_resp_o,
  output logic [31:0]                       stall_cycles_o
);

  localparam int unsigned CntW   = $clog2(MaxOutstanding + 1);
  localparam int unsigned NumIds = 2 ** MetaIdWidth;
  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);
  localparam logic [CntW-1:0] OneCnt = CntW'(1);

  logic [CntW-1:0]   r_count;
  logic [NumIds-1:0] r_busy;
  logic              r_spurious;

  logic w_full, w_block, w_req_hs, w_rsp_hs, w_rsp_known, w_rsp_retire;

  assign tcdm.q = core.q;

  assign w_full  = (r_count == MaxCnt);
  assign w_block = w_full | r_busy[core.q.id] | fence_i;

  assign tcdm.q_valid = core.q_valid & ~w_block & ~rst_i;
  assign core.q_ready = tcdm.q_ready & ~w_block & ~rst_i;

  assign w_req_hs     = tcdm.q_valid & tcdm.q_ready;
  assign w_rsp_hs     = tcdm.p_valid & tcdm.p_ready & ~rst_i;
  assign w_rsp_known  = r_busy[tcdm.p.id];
  assign w_rsp_retire = w_rsp_hs & w_rsp_known;

  // Only responses for tracked ids retire; that keeps count from underflowing.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_count    <= '0;
      r_busy     <= '0;
      r_spurious <= 1'b0;
    end else begin
      if (w_req_hs && !w_rsp_retire)      r_count <= r_count + OneCnt;
      else if (!w_req_hs && w_rsp_retire) r_count <= r_count - OneCnt;
      if (w_rsp_retire) r_busy[tcdm.p.id] <= 1'b0;
      if (w_req_hs)     r_busy[core.q.id] <= 1'b1;
      if (w_rsp_hs && !w_rsp_known) r_spurious <= 1'b1;
    end
  end

  assign idle_o          = (r_count == '0);
  assign spurious_resp_o = r_spurious;

  // Reset drains the interconnect: responses are accepted and never forwarded.
  if (RegisterResp) begin : g_spill
    logic w_spill_ready, w_spill_valid;
    mempool_tcdm_req_tracker_spill #(.T(dresp_t)) u_spill (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .valid_i (tcdm.p_valid),
      .ready_o (w_spill_ready),
      .data_i  (tcdm.p),
      .valid_o (w_spill_valid),
      .ready_i (core.p_ready),
      .data_o  (core.p)
    );
    assign tcdm.p_ready = w_spill_ready | rst_i;
    assign core.p_valid = w_spill_valid & ~rst_i;
  end else begin : g_pass
    assign core.p       = tcdm.p;
    assign core.p_valid = tcdm.p_valid & ~rst_i;
    assign tcdm.p_ready = core.p_ready | rst_i;
  end

`ifdef MEMPOOL_TCDM_STATS_EN
  logic [31:0] r_stall_cycles;
  always_ff @(posedge clk_i) begin
    if (rst_i)                        r_stall_cycles <= '0;
    else if (core.q_valid && w_block) r_stall_cycles <= sat_inc32(r_stall_cycles);
  end
  assign stall_cycles_o = r_stall_cycles;
`else
  assign stall_cycles_o = '0;
`endif

endmodule

// File: tb/tb_mempool_tcdm_req_tracker.sv
// Directed bench: default tracker (MaxOutstanding=8) plus a MaxOutstanding=2 instance.
module tb_mempool_tcdm_req_tracker;
  import mempool_tcdm_req_tracker_pkg::*;

`ifdef MEMPOOL_TCDM_STATS_EN
  localparam logic [31:0] STALL_EXP = 32'd10;
`else
  localparam logic [31:0] STALL_EXP = 32'd0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic fence, fence2;
  logic idle, spur, idle2, spur2;
  logic [31:0] stall, stall2;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mempool_tcdm_req_tracker_if c_if ();
  mempool_tcdm_req_tracker_if t_if ();
  mempool_tcdm_req_tracker_if c2_if ();
  mempool_tcdm_req_tracker_if t2_if ();

  mempool_tcdm_req_tracker u_dut (
    .clk_i(clk), .rst_i(rst), .core(c_if), .tcdm(t_if), .fence_i(fence),
    .idle_o(idle), .spurious_resp_o(spur), .stall_cycles_o(stall)
  );

  mempool_tcdm_req_tracker #(.MaxOutstanding(2)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .core(c2_if), .tcdm(t2_if), .fence_i(fence2),
    .idle_o(idle2), .spurious_resp_o(spur2), .stall_cycles_o(stall2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic v, input meta_id_t id);
    c_if.q_valid = v;
    c_if.q.id    = id;
    c_if.q.addr  = 32'h1000_0000 | {26'd0, id, 2'b00};
  endtask

  task automatic rsp(input logic v, input meta_id_t id);
    t_if.p_valid = v;
    t_if.p.id    = id;
    t_if.p.data  = 32'hD000_0000 | 32'(id);
    t_if.p.error = 1'b0;
  endtask

  task automatic req2(input logic v, input meta_id_t id);
    c2_if.q_valid = v;
    c2_if.q.id    = id;
  endtask

  task automatic rsp2(input logic v, input meta_id_t id);
    t2_if.p_valid = v;
    t2_if.p.id    = id;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; fence = 1'b0; fence2 = 1'b0;
    c_if.q = '0; c_if.p_ready = 1'b1; t_if.q_ready = 1'b1; t_if.p = '0;
    c2_if.q = '0; c2_if.p_ready = 1'b1; t2_if.q_ready = 1'b1; t2_if.p = '0;
    req(1'b1, 4'd0); rsp(1'b1, 4'd9); req2(1'b0, 4'd0); rsp2(1'b0, 4'd0);
    tick();
    checks++; if (t_if.q_valid !== 1'b0) begin errors++; $display("FAIL rst_qvalid: got %b want 0", t_if.q_valid); end
    checks++; if (c_if.q_ready !== 1'b0) begin errors++; $display("FAIL rst_qready: got %b want 0", c_if.q_ready); end
    checks++; if (t_if.p_ready !== 1'b1) begin errors++; $display("FAIL rst_pready: got %b want 1", t_if.p_ready); end
    checks++; if (c_if.p_valid !== 1'b0) begin errors++; $display("FAIL rst_pvalid: got %b want 0", c_if.p_valid); end
    tick();
    rst = 1'b0; req(1'b0, 4'd0); rsp(1'b0, 4'd0);
    #1;
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rst_idle: got %b want 1", idle); end
    checks++; if (spur !== 1'b0) begin errors++; $display("FAIL rst_spur: got %b want 0", spur); end
    checks++; if (stall !== 32'd0) begin errors++; $display("FAIL rst_stall: got %0d want 0", stall); end
    checks++; if (c_if.q_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after: got %b want 1", c_if.q_ready); end
  endtask

  task automatic test_passthrough();
    c_if.q.addr = 32'hCAFE_0010; c_if.q.write = 1'b1; c_if.q.amo = 4'h3;
    c_if.q.data = 32'h1234_5678; c_if.q.strb = 4'hA; c_if.q.id = 4'd1;
    rsp(1'b1, 4'd7);
    #1;
    checks++; if (t_if.q.addr !== 32'hCAFE_0010) begin errors++; $display("FAIL pt_addr: got %h want cafe0010", t_if.q.addr); end
    checks++; if (t_if.q.data !== 32'h1234_5678 || t_if.q.strb !== 4'hA || t_if.q.write !== 1'b1 || t_if.q.amo !== 4'h3)
      begin errors++; $display("FAIL pt_fields: got %h/%h/%b/%h want 12345678/a/1/3", t_if.q.data, t_if.q.strb, t_if.q.write, t_if.q.amo); end
    checks++; if (c_if.p_valid !== 1'b1 || c_if.p.data !== 32'hD000_0007)
      begin errors++; $display("FAIL pt_resp: got %b/%h want 1/d0000007", c_if.p_valid, c_if.p.data); end
    rsp(1'b0, 4'd0);
    c_if.q = '0;
  endtask

  task automatic test_max_outstanding();
    req2(1'b1, 4'd0); #1;
    checks++; if (c2_if.q_ready !== 1'b1) begin errors++; $display("FAIL max_id0: got %b want 1", c2_if.q_ready); end
    tick();
    req2(1'b1, 4'd1); #1;
    checks++; if (c2_if.q_ready !== 1'b1) begin errors++; $display("FAIL max_id1: got %b want 1", c2_if.q_ready); end
    tick();
    req2(1'b1, 4'd2); #1;
    checks++; if (c2_if.q_ready !== 1'b0 || t2_if.q_valid !== 1'b0)
      begin errors++; $display("FAIL max_id2_stall: got ready %b valid %b want 0 0", c2_if.q_ready, t2_if.q_valid); end
    checks++; if (idle2 !== 1'b0) begin errors++; $display("FAIL max_idle: got %b want 0", idle2); end
    tick();
    checks++; if (c2_if.q_ready !== 1'b0) begin errors++; $display("FAIL max_still: got %b want 0", c2_if.q_ready); end
    rsp2(1'b1, 4'd0);
    tick();
    rsp2(1'b0, 4'd0); #1;
    checks++; if (c2_if.q_ready !== 1'b1) begin errors++; $display("FAIL max_freed: got %b want 1", c2_if.q_ready); end
    tick();
    req2(1'b0, 4'd0);
    rsp2(1'b1, 4'd1); tick();
    rsp2(1'b1, 4'd2); tick();
    rsp2(1'b0, 4'd0); #1;
    checks++; if (idle2 !== 1'b1) begin errors++; $display("FAIL max_drain_idle: got %b want 1", idle2); end
  endtask

  task automatic test_dup_id();
    req(1'b1, 4'd3); tick(); #1;
    checks++; if (c_if.q_ready !== 1'b0) begin errors++; $display("FAIL dup_block: got %b want 0", c_if.q_ready); end
    tick();
    checks++; if (c_if.q_ready !== 1'b0) begin errors++; $display("FAIL dup_block2: got %b want 0", c_if.q_ready); end
    rsp(1'b1, 4'd3); #1;
    checks++; if (c_if.q_ready !== 1'b0) begin errors++; $display("FAIL dup_rsp_cycle: got %b want 0", c_if.q_ready); end
    tick();
    rsp(1'b0, 4'd0); #1;
    checks++; if (c_if.q_ready !== 1'b1) begin errors++; $display("FAIL dup_release: got %b want 1", c_if.q_ready); end
    tick();
    req(1'b0, 4'd0);
    checks++; if (idle !== 1'b0) begin errors++; $display("FAIL dup_reissued: got idle %b want 0", idle); end
    rsp(1'b1, 4'd3); tick();
    rsp(1'b0, 4'd0);
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL dup_idle: got %b want 1", idle); end
  endtask

  task automatic test_simultaneous();
    req(1'b1, 4'd4); tick();
    req(1'b1, 4'd5); rsp(1'b1, 4'd4); #1;
    checks++; if (c_if.q_ready !== 1'b1) begin errors++; $display("FAIL sim_ready: got %b want 1", c_if.q_ready); end
    tick();
    req(1'b0, 4'd5); rsp(1'b0, 4'd0); #1;
    checks++; if (idle !== 1'b0) begin errors++; $display("FAIL sim_count1: got idle %b want 0", idle); end
    checks++; if (c_if.q_ready !== 1'b0) begin errors++; $display("FAIL sim_busy5: got ready %b want 0", c_if.q_ready); end
    req(1'b0, 4'd4); #1;
    checks++; if (c_if.q_ready !== 1'b1) begin errors++; $display("FAIL sim_free4: got ready %b want 1", c_if.q_ready); end
    rsp(1'b1, 4'd5); tick();
    rsp(1'b0, 4'd0);
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL sim_idle: got %b want 1", idle); end
  endtask

  task automatic test_spurious();
    rsp(1'b1, 4'd7); tick();
    rsp(1'b0, 4'd0);
    checks++; if (spur !== 1'b1 || idle !== 1'b1) begin errors++; $display("FAIL spur_set: got spur %b idle %b want 1 1", spur, idle); end
    repeat (3) tick();
    checks++; if (spur !== 1'b1) begin errors++; $display("FAIL spur_sticky: got %b want 1", spur); end
    do_reset(); #1;
    checks++; if (spur !== 1'b0) begin errors++; $display("FAIL spur_clear: got %b want 0", spur); end
    req(1'b1, 4'd2); tick();
    req(1'b0, 4'd0);
    checks++; if (idle !== 1'b0) begin errors++; $display("FAIL spur_inflight: got idle %b want 0", idle); end
    do_reset(); #1;
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL spur_rst_idle: got %b want 1", idle); end
    rsp(1'b1, 4'd2); tick();
    rsp(1'b0, 4'd0);
    checks++; if (spur !== 1'b1 || idle !== 1'b1) begin errors++; $display("FAIL spur_stale: got spur %b idle %b want 1 1", spur, idle); end
    do_reset();
  endtask

  task automatic test_fence();
    req(1'b1, 4'd0); tick();
    req(1'b1, 4'd1); tick();
    req(1'b1, 4'd2); tick();
    fence = 1'b1; req(1'b1, 4'd6); #1;
    checks++; if (c_if.q_ready !== 1'b0) begin errors++; $display("FAIL fence_block: got %b want 0", c_if.q_ready); end
    rsp(1'b1, 4'd0); tick();
    rsp(1'b1, 4'd1); tick();
    rsp(1'b1, 4'd2); tick();
    rsp(1'b0, 4'd0); #1;
    checks++; if (idle !== 1'b1 || c_if.q_ready !== 1'b0)
      begin errors++; $display("FAIL fence_drained: got idle %b ready %b want 1 0", idle, c_if.q_ready); end
    tick();
    fence = 1'b0; #1;
    checks++; if (c_if.q_ready !== 1'b1 || t_if.q_valid !== 1'b1)
      begin errors++; $display("FAIL fence_release: got ready %b valid %b want 1 1", c_if.q_ready, t_if.q_valid); end
    tick();
    req(1'b0, 4'd0);
    checks++; if (idle !== 1'b0) begin errors++; $display("FAIL fence_issued: got idle %b want 0", idle); end
    rsp(1'b1, 4'd6); tick();
    rsp(1'b0, 4'd0);
  endtask

  task automatic test_stats();
    do_reset();
    fence = 1'b1; req(1'b1, 4'd0);
    repeat (10) tick();
    req(1'b0, 4'd0); fence = 1'b0;
    checks++; if (stall !== STALL_EXP) begin errors++; $display("FAIL stall_count: got %0d want %0d", stall, STALL_EXP); end
    repeat (2) tick();
    checks++; if (stall !== STALL_EXP) begin errors++; $display("FAIL stall_hold: got %0d want %0d", stall, STALL_EXP); end
    checks++; if (stall2 !== 32'd0) begin errors++; $display("FAIL stall2_zero: got %0d want 0", stall2); end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_max_outstanding();
    test_dup_id();
    test_simultaneous();
    test_spurious();
    test_fence();
    test_stats();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
